// File: rtl/lms_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lms_pkg
// Brief    : Shared types, default widths and helpers for the LMS tap sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package lms_pkg;

    localparam int DEF_X_W = 16;
    localparam int DEF_E_W = 16;
    localparam int DEF_W_W = 16;
    localparam int SAT_W   = 64;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FIRE = 3'd1,
        WAIT = 3'd2,
        SUM  = 3'd3,
        CALC = 3'd4
    } lms_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((r < 30) && ((1 << r) < n)) r = r + 1;
        return r;
    endfunction

    // Clamp a wide signed value into the range of a w-bit signed number.
    function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                         input int w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
        lo = -hi - SAT_W'(1);
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lms_err_calc.sv
`default_nettype none
// ============================================================================
// Module   : lms_err_calc
// Brief    : Combinational y = sat(acc >>> Y_SHIFT), e = sat((d - y) >>> MU_SHIFT).
// Revision : 1.0 - initial release
// ============================================================================
module lms_err_calc
    import lms_pkg::*;
#(
    parameter int ACC_W    = 35,
    parameter int X_W      = DEF_X_W,
    parameter int E_W      = DEF_E_W,
    parameter int Y_SHIFT  = 15,
    parameter int MU_SHIFT = 4
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [X_W-1:0]   d,
    output logic signed [X_W-1:0]   y,
    output logic signed [E_W-1:0]   e
);

    logic signed [ACC_W-1:0] w_acc_sh;
    logic signed [X_W:0]     w_diff;
    logic signed [X_W:0]     w_diff_sh;

    assign w_acc_sh  = acc >>> Y_SHIFT;
    assign y         = X_W'(saturate(SAT_W'(w_acc_sh), X_W));
    // One extra bit keeps d - y exact before the step-size shift.
    assign w_diff    = (X_W+1)'(d) - (X_W+1)'(y);
    assign w_diff_sh = w_diff >>> MU_SHIFT;
    assign e         = E_W'(saturate(SAT_W'(w_diff_sh), E_W));

endmodule
`default_nettype wire

// File: rtl/lms_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lms_tap_sequencer
// Brief    : Per-sample controller for an array of LMS tap units: delay line,
//            tap handshake with timeout, serial product sum and error update.
//            Optional macro LMS_ADAPT_GATE_EN adds adapt_en to freeze taps.
// Revision : 1.0 - initial release
// ============================================================================
module lms_tap_sequencer
    import lms_pkg::*;
#(
    parameter int NUM_TAPS = 8,
    parameter int X_W      = DEF_X_W,
    parameter int E_W      = DEF_E_W,
    parameter int W_W      = DEF_W_W,
    parameter int Y_SHIFT  = 15,
    parameter int MU_SHIFT = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [X_W-1:0]                x_in,
    input  logic [X_W-1:0]                d_in,
    output logic                          tap_en,
    output logic [NUM_TAPS*X_W-1:0]       tap_xin,
    output logic [E_W-1:0]                tap_err,
    input  logic [NUM_TAPS*(X_W+W_W)-1:0] tap_yout,
    input  logic [NUM_TAPS-1:0]           tap_update,
    output logic                          out_valid,
    output logic [X_W-1:0]                y_out,
    output logic [E_W-1:0]                e_out,
    output logic                          fault
`ifdef LMS_ADAPT_GATE_EN
    ,
    input  logic                          adapt_en
`endif
);

    localparam int c_P_W   = X_W + W_W;
    localparam int c_ACC_W = c_P_W + clog2(NUM_TAPS);
    localparam int c_IDX_W = clog2(NUM_TAPS);
    localparam int c_CNT_W = clog2(TIMEOUT + 1);

    lms_state_t                r_state;
    lms_state_t                w_next_state;
    logic [X_W-1:0]            r_dline [NUM_TAPS];
    logic signed [X_W-1:0]     r_d;
    logic [E_W-1:0]            r_err;
    logic signed [c_ACC_W-1:0] r_acc;
    logic [c_IDX_W-1:0]        r_idx;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [NUM_TAPS-1:0]       r_seen;
    logic [X_W-1:0]            r_y;
    logic [E_W-1:0]            r_e;
    logic                      r_out_valid;
    logic                      r_fault;

    logic signed [c_P_W-1:0]   w_yout [NUM_TAPS];
    logic [NUM_TAPS-1:0]       w_seen_now;
    logic                      w_all_seen;
    logic                      w_timeout;
    logic                      w_sum_last;
    logic signed [X_W-1:0]     w_y;
    logic signed [E_W-1:0]     w_e;

    genvar k;
    generate
        for (k = 0; k < NUM_TAPS; k++) begin : g_tap
            assign tap_xin[k*X_W +: X_W] = r_dline[k];
            assign w_yout[k]             = tap_yout[k*c_P_W +: c_P_W];
        end
    endgenerate

    // Bits arriving this cycle count, so the mask test looks at the merged value.
    assign w_seen_now = r_seen | tap_update;
    assign w_all_seen = &w_seen_now;
    assign w_timeout  = (r_cnt == c_CNT_W'(TIMEOUT - 1));
    assign w_sum_last = (r_idx == c_IDX_W'(NUM_TAPS - 1));

    lms_err_calc #(
        .ACC_W    (c_ACC_W),
        .X_W      (X_W),
        .E_W      (E_W),
        .Y_SHIFT  (Y_SHIFT),
        .MU_SHIFT (MU_SHIFT)
    ) u_err_calc (
        .acc (r_acc),
        .d   (r_d),
        .y   (w_y),
        .e   (w_e)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (in_valid) w_next_state = FIRE;
            FIRE: w_next_state = WAIT;
            WAIT: begin
                if (w_all_seen)     w_next_state = SUM;
                else if (w_timeout) w_next_state = IDLE;
            end
            SUM:  if (w_sum_last) w_next_state = CALC;
            CALC: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        tap_en   = 1'b0;
        case (r_state)
            IDLE:    in_ready = 1'b1;
            FIRE:    tap_en   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TAPS; i++) r_dline[i] <= '0;
            r_d         <= '0;
            r_err       <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_seen      <= '0;
            r_y         <= '0;
            r_e         <= '0;
            r_out_valid <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_dline[0] <= x_in;
                        for (int i = 1; i < NUM_TAPS; i++) r_dline[i] <= r_dline[i-1];
                        r_d <= d_in;
                    end
                end
                FIRE: begin
                    r_seen <= '0;
                    r_cnt  <= '0;
                    r_acc  <= '0;
                    r_idx  <= '0;
                end
                WAIT: begin
                    r_seen <= w_seen_now;
                    r_cnt  <= r_cnt + c_CNT_W'(1);
                    if (!w_all_seen && w_timeout) r_fault <= 1'b1;
                end
                SUM: begin
                    r_acc <= r_acc + c_ACC_W'(w_yout[r_idx]);
                    r_idx <= r_idx + c_IDX_W'(1);
                end
                CALC: begin
                    r_y         <= w_y;
                    r_e         <= w_e;
                    r_err       <= w_e;
                    r_out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef LMS_ADAPT_GATE_EN
    assign tap_err = adapt_en ? r_err : '0;
`else
    assign tap_err = r_err;
`endif

    assign out_valid = r_out_valid;
    assign y_out     = r_y;
    assign e_out     = r_e;
    assign fault     = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_lms_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lms_tap_sequencer
// Brief    : Self-checking bench for lms_tap_sequencer with a tap-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lms_tap_sequencer;

    localparam int NT = 8;
    localparam int XW = 16;
    localparam int EW = 16;
    localparam int PW = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [XW-1:0]     x_in = '0;
    logic [XW-1:0]     d_in = '0;
    logic              tap_en;
    logic [NT*XW-1:0]  tap_xin;
    logic [EW-1:0]     tap_err;
    logic [NT*PW-1:0]  tap_yout = '0;
    logic [NT-1:0]     tap_update = '0;
    logic              out_valid;
    logic [XW-1:0]     y_out;
    logic [EW-1:0]     e_out;
    logic              fault;
`ifdef LMS_ADAPT_GATE_EN
    logic              adapt_en = 1'b1;
`endif

    int checks = 0;
    int errors = 0;

    logic signed [XW-1:0] hist [NT];
    logic signed [EW-1:0] m_err;
    logic signed [PW-1:0] yv [NT];

    always #5 clk = ~clk;

    lms_tap_sequencer #(
        .NUM_TAPS(NT), .X_W(XW), .E_W(EW), .W_W(16),
        .Y_SHIFT(15), .MU_SHIFT(4), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .d_in(d_in), .tap_en(tap_en), .tap_xin(tap_xin),
        .tap_err(tap_err), .tap_yout(tap_yout), .tap_update(tap_update),
        .out_valid(out_valid), .y_out(y_out), .e_out(e_out), .fault(fault)
`ifdef LMS_ADAPT_GATE_EN
        , .adapt_en(adapt_en)
`endif
    );

    // ---------------- reference model ----------------
    function automatic longint clamp(input longint v, input int w);
        longint hi;
        hi = (longint'(1) <<< (w - 1)) - 1;
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NT; k++) hist[k] = '0;
        m_err = '0;
    endfunction

    function automatic void model_accept(input logic signed [XW-1:0] x);
        for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x;
    endfunction

    function automatic logic [NT*XW-1:0] model_xin();
        logic [NT*XW-1:0] v;
        for (int k = 0; k < NT; k++) v[k*XW +: XW] = hist[k];
        return v;
    endfunction

    function automatic void model_out(input logic signed [XW-1:0] d,
                                      output logic signed [XW-1:0] ey,
                                      output logic signed [EW-1:0] ee);
        longint s, df;
        s = 0;
        for (int k = 0; k < NT; k++) s += longint'(yv[k]);
        ey = XW'(clamp(s >>> 15, XW));
        df = longint'(d) - longint'(ey);
        ee = EW'(clamp(df >>> 4, EW));
    endfunction

    task automatic set_yout();
        for (int k = 0; k < NT; k++) tap_yout[k*PW +: PW] = yv[k];
    endtask

    task automatic rand_yout(input bit big);
        for (int k = 0; k < NT; k++)
            if (big) yv[k] = $urandom;
            else     yv[k] = PW'($urandom_range(0, 2097151)) - 32'sd1048576;
        set_yout();
    endtask

    // Drives one sample and plays the tap array; returns what it observed.
    task automatic run_sample(input logic [XW-1:0] x, input logic [XW-1:0] d,
                              input int stagger, input logic [NT-1:0] dead, input bit hold,
                              output int lat, output int end_n,
                              output logic [XW-1:0] yo, output logic [EW-1:0] eo,
                              output logic [EW-1:0] ferr, output logic [NT*XW-1:0] fxin);
        int fire_n;
        fire_n = -1; lat = -1; end_n = -1;
        yo = '0; eo = '0; ferr = '0; fxin = '0;
        x_in = x; d_in = d; in_valid = 1'b1;
        @(posedge clk); #1;
        if (!hold) in_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (tap_en) begin fire_n = n; ferr = tap_err; fxin = tap_xin; end
            if (out_valid) begin lat = n; yo = y_out; eo = e_out; end
            tap_update = '0;
            if (fire_n > 0)
                for (int k = 0; k < NT; k++)
                    if (!dead[k] && n == fire_n + 1 + (k % stagger)) tap_update[k] = 1'b1;
            if (out_valid || (n > 1 && in_ready)) begin end_n = n; break; end
            @(posedge clk); #1;
        end
        tap_update = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; tap_update = '0;
        for (int k = 0; k < NT; k++) yv[k] = '0;
        set_yout();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        checks++; if (tap_en !== 1'b0) begin errors++; $display("FAIL rst_tap_en got %b want 0", tap_en); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b want 0", fault); end
        checks++; if (tap_xin !== '0) begin errors++; $display("FAIL rst_tap_xin got %h want 0", tap_xin); end
        checks++; if (tap_err !== '0) begin errors++; $display("FAIL rst_tap_err got %h want 0", tap_err); end
        checks++; if (y_out !== '0 || e_out !== '0) begin errors++; $display("FAIL rst_y_e got %h/%h want 0/0", y_out, e_out); end
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int lat, end_n;
        logic [XW-1:0] yo; logic [EW-1:0] eo, ferr; logic [NT*XW-1:0] fxin;
        // zero products, first sample after reset
        run_sample(16'd100, 16'd0, 1, '0, 1'b0, lat, end_n, yo, eo, ferr, fxin);
        model_accept(16'sd100);
        checks++; if (lat != 12) begin errors++; $display("FAIL dir_latency got %0d want 12", lat); end
        checks++; if (yo !== 16'd0 || eo !== 16'd0) begin errors++; $display("FAIL dir_zero_y_e got %0d/%0d want 0/0", yo, eo); end
        checks++; if (ferr !== 16'd0) begin errors++; $display("FAIL dir_first_err got %0d want 0", ferr); end
        checks++; if (fxin !== model_xin()) begin errors++; $display("FAIL dir_xin got %h want %h", fxin, model_xin()); end
        // unity products, d = 20
        for (int k = 0; k < NT; k++) yv[k] = 32'sd32768;
        set_yout();
        run_sample(16'd5, 16'd20, 1, '0, 1'b0, lat, end_n, yo, eo, ferr, fxin);
        model_accept(16'sd5);
        checks++; if (ferr !== 16'd0) begin errors++; $display("FAIL dir_err_after_zero got %0d want 0", ferr); end
        checks++; if (yo !== 16'd8 || eo !== 16'd0) begin errors++; $display("FAIL dir_unity_d20 got %0d/%0d want 8/0", yo, eo); end
        run_sample(16'd6, 16'd200, 1, '0, 1'b0, lat, end_n, yo, eo, ferr, fxin);
        model_accept(16'sd6);
        checks++; if (yo !== 16'd8 || eo !== 16'd12) begin errors++; $display("FAIL dir_unity_d200 got %0d/%0d want 8/12", yo, eo); end
        // saturation
        for (int k = 0; k < NT; k++) yv[k] = 32'sh3FFF_FFFF;
        set_yout();
        run_sample(16'd7, 16'h8000, 1, '0, 1'b0, lat, end_n, yo, eo, ferr, fxin);
        model_accept(16'sd7);
        checks++; if (ferr !== 16'd12) begin errors++; $display("FAIL dir_err_broadcast got %0d want 12", ferr); end
        checks++; if (yo !== 16'h7FFF) begin errors++; $display("FAIL dir_y_sat got %h want 7fff", yo); end
        checks++; if (eo !== 16'hF000) begin errors++; $display("FAIL dir_e_sat got %h want f000", eo); end
        checks++; if (fxin !== model_xin()) begin errors++; $display("FAIL dir_xin_hist got %h want %h", fxin, model_xin()); end
        m_err = 16'shF000;
    endtask

    task automatic test_timeout();
        int lat, end_n;
        logic [XW-1:0] x, d, yo; logic [EW-1:0] eo, ferr; logic [NT*XW-1:0] fxin;
        logic signed [XW-1:0] ey; logic signed [EW-1:0] ee;
        rand_yout(1'b0);
        x = XW'($urandom); d = XW'($urandom);
        run_sample(x, d, 1, 8'h20, 1'b0, lat, end_n, yo, eo, ferr, fxin);
        model_accept(x);
        checks++; if (lat != -1) begin errors++; $display("FAIL to_no_out_valid got lat %0d want none", lat); end
        checks++; if (end_n != 17) begin errors++; $display("FAIL to_idle_cycle got %0d want 17", end_n); end
        checks++; if (fault !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL to_fault_ready got %b/%b want 1/1", fault, in_ready); end
        checks++; if (ferr !== m_err) begin errors++; $display("FAIL to_err got %h want %h", ferr, m_err); end
        x = XW'($urandom); d = XW'($urandom);
        run_sample(x, d, 1, '0, 1'b0, lat, end_n, yo, eo, ferr, fxin);
        model_accept(x);
        model_out(d, ey, ee);
        checks++; if (fxin !== model_xin()) begin errors++; $display("FAIL to_xin_kept got %h want %h", fxin, model_xin()); end
        checks++; if (lat != 12 || yo !== ey || eo !== ee) begin errors++; $display("FAIL to_recover got lat %0d y %h e %h want 12 %h %h", lat, yo, eo, ey, ee); end
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL to_fault_sticky got %b want 1", fault); end
        m_err = ee;
    endtask

    task automatic test_back_to_back();
        int lat, end_n;
        logic [XW-1:0] x, d, yo; logic [EW-1:0] eo, ferr; logic [NT*XW-1:0] fxin;
        logic signed [XW-1:0] ey; logic signed [EW-1:0] ee;
        rand_yout(1'b0);
        for (int s = 0; s < 10; s++) begin
            x = XW'(s + 1); d = XW'($urandom);
            run_sample(x, d, 3, '0, 1'b1, lat, end_n, yo, eo, ferr, fxin);
            model_accept(x);
            model_out(d, ey, ee);
            checks++; if (fxin !== model_xin()) begin errors++; $display("FAIL b2b_xin s%0d got %h want %h", s, fxin, model_xin()); end
            checks++; if (ferr !== m_err) begin errors++; $display("FAIL b2b_err s%0d got %h want %h", s, ferr, m_err); end
            checks++; if (lat != NT + 6 || yo !== ey || eo !== ee) begin errors++; $display("FAIL b2b_out s%0d got lat %0d y %h e %h want %0d %h %h", s, lat, yo, eo, NT + 6, ey, ee); end
            m_err = ee;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        int lat, end_n, stg;
        logic [XW-1:0] x, d, yo; logic [EW-1:0] eo, ferr; logic [NT*XW-1:0] fxin;
        logic signed [XW-1:0] ey; logic signed [EW-1:0] ee;
        for (int s = 0; s < 20; s++) begin
            rand_yout(1'($urandom_range(0, 1)));
            stg = $urandom_range(1, 3);
            x = XW'($urandom); d = XW'($urandom);
            run_sample(x, d, stg, '0, 1'b0, lat, end_n, yo, eo, ferr, fxin);
            model_accept(x);
            model_out(d, ey, ee);
            checks++; if (fxin !== model_xin() || ferr !== m_err) begin errors++; $display("FAIL rnd_fire s%0d got %h/%h want %h/%h", s, fxin, ferr, model_xin(), m_err); end
            checks++; if (lat != NT + 3 + stg) begin errors++; $display("FAIL rnd_latency s%0d got %0d want %0d", s, lat, NT + 3 + stg); end
            checks++; if (yo !== ey || eo !== ee) begin errors++; $display("FAIL rnd_out s%0d got %h/%h want %h/%h", s, yo, eo, ey, ee); end
            m_err = ee;
        end
    endtask

`ifdef LMS_ADAPT_GATE_EN
    task automatic test_adapt_gate();
        int lat, end_n;
        logic [XW-1:0] yo; logic [EW-1:0] eo, ferr; logic [NT*XW-1:0] fxin;
        logic signed [XW-1:0] ey; logic signed [EW-1:0] ee;
        for (int k = 0; k < NT; k++) yv[k] = '0;
        set_yout();
        run_sample(16'd1, 16'd4000, 1, '0, 1'b0, lat, end_n, yo, eo, ferr, fxin);
        model_accept(16'sd1);
        m_err = 16'sd250;
        adapt_en = 1'b0;
        run_sample(16'd2, 16'd3000, 1, '0, 1'b0, lat, end_n, yo, eo, ferr, fxin);
        model_accept(16'sd2);
        model_out(16'sd3000, ey, ee);
        checks++; if (ferr !== 16'd0) begin errors++; $display("FAIL gate_err got %h want 0", ferr); end
        checks++; if (eo !== ee || eo === 16'd0) begin errors++; $display("FAIL gate_e_out got %h want %h", eo, ee); end
        adapt_en = 1'b1;
        m_err = ee;
    endtask
`endif

    task automatic test_reset_mid();
        bit seen_ov;
        rand_yout(1'b0);
        x_in = 16'h1234; d_in = 16'h0100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        tap_update = '1;
        @(posedge clk); #1;
        tap_update = '0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || tap_en !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_ctrl got rdy %b en %b ov %b want 1 0 0", in_ready, tap_en, out_valid); end
        checks++; if (tap_xin !== '0 || tap_err !== '0) begin errors++; $display("FAIL mid_taps got %h/%h want 0/0", tap_xin, tap_err); end
        checks++; if (y_out !== '0 || e_out !== '0 || fault !== 1'b0) begin errors++; $display("FAIL mid_outs got %h/%h/%b want 0/0/0", y_out, e_out, fault); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        seen_ov = 1'b0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            if (out_valid) seen_ov = 1'b1;
        end
        checks++; if (seen_ov) begin errors++; $display("FAIL mid_abandon got out_valid 1 want 0"); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_back_to_back();
        test_random();
`ifdef LMS_ADAPT_GATE_EN
        test_adapt_gate();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
